// File: rtl/hazard_unit_mc.sv
`default_nettype none
// hazard_unit_mc: forwarding, load-use stall, mispredict flush and multi-cycle E hold FSM.
// Optional perf counters built only when HAZ_PERF_CNT_EN is defined.
module hazard_unit_mc #(
    parameter int         REG_AW      = 5,
    parameter int         MDU_LATENCY = 4,
    parameter logic [1:0] LOAD_SRC    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MduStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MduBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam int CNT_BITS = ($clog2(MDU_LATENCY) < 3) ? 3 : $clog2(MDU_LATENCY);
    localparam bit MULTI    = (MDU_LATENCY > 1);
    localparam int LOAD_CNT = MULTI ? (MDU_LATENCY - 2) : 0;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                mdu_stall;
    logic                lwstall;

    // M-stage result is newer than W-stage, so it wins when both match.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    assign lwstall = !rst && (ResultSrcE == LOAD_SRC) && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MduStartE && MULTI) begin
                    mdu_stall = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_BITS'(LOAD_CNT);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset aborts any hold in the same cycle it is asserted.
        if (rst)
            mdu_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign StallF  = lwstall | mdu_stall;
    assign StallD  = lwstall | mdu_stall;
    assign StallE  = mdu_stall;
    assign FlushM  = mdu_stall;
    assign FlushE  = (lwstall | (PCSrcE & ~rst)) & ~mdu_stall;
    assign FlushD  = PCSrcE & ~rst & ~mdu_stall;
    assign MduBusy = (state_q == BUSY);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters: stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((FlushD || FlushE) && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// tb_hazard_unit_mc: directed vectors feed an expected-value queue; a negedge monitor checks.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteM, RegWriteW;
    logic [4:0] RdM, RdW, Rs1E, Rs2E, Rs1D, Rs2D, RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MduStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;
    logic [3:0] StallCnt, FlushCnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_AW(5), .MDU_LATENCY(4), .LOAD_SRC(2'b01), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RdM(RdM), .RdW(RdW), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MduBusy(MduBusy), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    typedef struct {
        logic       rst, rwm, rww;
        logic [4:0] rdm, rdw, rs1e, rs2e, rs1d, rs2d, rde;
        logic [1:0] rsrc;
        logic       pcsrc, mdu;
    } in_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fm, busy, busy_x;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    bit   done   = 1'b0;

    function automatic in_t nop();
        in_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic sf, input logic sd, input logic se,
                                input logic fd, input logic fe, input logic fm,
                                input logic busy);
        exp_t e;
        e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se;
        e.fd = fd; e.fe = fe; e.fm = fm; e.busy = busy; e.busy_x = 1'b0; e.id = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s vec%0d got %0h expected %0h", nm, id, act, ex);
        end
    endtask

    task automatic step(input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        rst = v.rst; RegWriteM = v.rwm; RegWriteW = v.rww;
        RdM = v.rdm; RdW = v.rdw; Rs1E = v.rs1e; Rs2E = v.rs2e;
        Rs1D = v.rs1d; Rs2D = v.rs2d; RdE = v.rde;
        ResultSrcE = v.rsrc; PCSrcE = v.pcsrc; MduStartE = v.mdu;
        e.id = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: the unit is combinational over registered state, so every cycle is an output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ForwardAE", e.id, {2'b00, ForwardAE}, {2'b00, e.fa});
                chk("ForwardBE", e.id, {2'b00, ForwardBE}, {2'b00, e.fb});
                chk("StallF",    e.id, {3'b000, StallF},   {3'b000, e.sf});
                chk("StallD",    e.id, {3'b000, StallD},   {3'b000, e.sd});
                chk("StallE",    e.id, {3'b000, StallE},   {3'b000, e.se});
                chk("FlushD",    e.id, {3'b000, FlushD},   {3'b000, e.fd});
                chk("FlushE",    e.id, {3'b000, FlushE},   {3'b000, e.fe});
                chk("FlushM",    e.id, {3'b000, FlushM},   {3'b000, e.fm});
                if (!e.busy_x)
                    chk("MduBusy", e.id, {3'b000, MduBusy}, {3'b000, e.busy});
            end
        end
    end

    initial begin
        in_t  v;
        exp_t e;
        int   wait_cyc;
        rst = 1'b1; RegWriteM = 1'b0; RegWriteW = 1'b0;
        RdM = '0; RdW = '0; Rs1E = '0; Rs2E = '0; Rs1D = '0; Rs2D = '0; RdE = '0;
        ResultSrcE = '0; PCSrcE = 1'b0; MduStartE = 1'b0;

        // Reset with hazards present on the inputs: everything must read zero.
        v = nop(); v.rst = 1'b1; v.rwm = 1'b1; v.rdm = 5; v.rs1e = 5;
        v.pcsrc = 1'b1; v.mdu = 1'b1; v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(nop(), mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // Forwarding priority and zero-register exclusion.
        v = nop(); v.rwm = 1; v.rdm = 5; v.rww = 1; v.rdw = 5; v.rs1e = 5; v.rs2e = 5;
        step(v, mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        v.rdm = 0; v.rs2e = 0;
        step(v, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        v = nop(); v.rwm = 0; v.rdm = 5; v.rww = 1; v.rdw = 5; v.rs1e = 3; v.rs2e = 5;
        step(v, mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        v = nop(); v.rww = 1; v.rdw = 0; v.rs1e = 0;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // Load-use: one cycle, then gone; RdE=0 and non-load never stall.
        v = nop(); v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7;
        step(v, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0));
        step(nop(), mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        v = nop(); v.rsrc = 2'b01; v.rde = 0; v.rs1d = 0;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        v = nop(); v.rsrc = 2'b10; v.rde = 7; v.rs1d = 7;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // Mispredict alone, then combined with a load-use stall.
        v = nop(); v.pcsrc = 1;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0));
        v = nop(); v.pcsrc = 1; v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7;
        step(v, mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0, 0));

        // Four-cycle MDU op.
        v = nop(); v.mdu = 1;
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0));
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        step(nop(), mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // MDU start alongside a load-use hazard: held E is never flushed.
        v = nop(); v.mdu = 1; v.rsrc = 2'b01; v.rde = 7; v.rs1d = 7;
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0));
        v = nop(); v.mdu = 1;
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        // Back-to-back op re-enters from IDLE, then reset during its second cycle.
        step(v, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0));
        v.rst = 1; v.rwm = 1; v.rdm = 4; v.rs1e = 4;
        e = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0); e.busy_x = 1'b1;
        step(v, e);
        v = nop(); v.rs1e = 4;
        step(v, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // 20 consecutive load-use cycles exercise counter saturation.
        v = nop(); v.rsrc = 2'b01; v.rde = 9; v.rs1d = 9;
        for (int i = 0; i < 20; i++)
            step(v, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0));
        step(nop(), mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZ_PERF_CNT_EN
        chk("StallCnt", vec_id, StallCnt, 4'd15);
        chk("FlushCnt", vec_id, FlushCnt, 4'd15);
`else
        chk("StallCnt", vec_id, StallCnt, 4'd0);
        chk("FlushCnt", vec_id, FlushCnt, 4'd0);
`endif

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
